rep_str_seq: RTL and testbench
==============================

REP_STR_SEQ -- requirements
Module: rep_str_seq

Interface
REQ-001 clk  in  1  clock; all state updates on rising edge.
REQ-002 rst  in  1  asynchronous, active-high reset.
REQ-003 valid_in  in  1  decoded instruction present at execute entry.
REQ-004 str_op  in  2  00 none, 01 MOVS, 10 STOS, 11 LODS.
REQ-005 is_rep  in  1  REP prefix present.
REQ-006 ecx_in, esi_in, edi_in  in  32 each  architectural ECX/ESI/EDI at instruction entry.
REQ-007 DF_in  in  1  direction flag; 0 increments, 1 decrements.
REQ-008 flush  in  1  pipeline flush; abort any sequence.
REQ-009 mem_ack  in  1  memory completed the current element transfer.
REQ-010 iter_valid  out  1  one-cycle request to perform one element transfer.
REQ-011 esi_out, edi_out, ecx_out  out  32 each  current pointer/count registers.
REQ-012 alu2_op  out  4  op code driven to the downstream ALU2 stage.
REQ-013 stall  out  1  hold upstream pipeline.
REQ-014 done  out  1  one-cycle pulse at sequence completion.

Function
REQ-015 States SHALL be IDLE, ITER, WAIT, DONE.
REQ-016 IDLE: on valid_in=1 and str_op!=00, ESI/EDI/ECX registers SHALL load esi_in/edi_in/ecx_in and DF SHALL be latched.
REQ-017 IDLE load with is_rep=1 and ecx_in=0 SHALL go to DONE with no iteration issued.
REQ-018 Otherwise IDLE load SHALL go to ITER; str_op=00 or valid_in=0 SHALL stay IDLE.
REQ-019 ITER SHALL assert iter_valid for exactly one cycle and go to WAIT.
REQ-020 WAIT SHALL hold all registers until mem_ack=1.
REQ-021 On mem_ack in WAIT: ESI SHALL step by 4 for MOVS/LODS, EDI SHALL step by 4 for MOVS/STOS; step is +4 if latched DF=0, -4 if DF=1.
REQ-022 Pointer arithmetic SHALL wrap modulo 2^32 (0xFFFFFFFC+4=0x00000000, 0x00000000-4=0xFFFFFFFC).
REQ-023 On mem_ack with is_rep=1, ECX SHALL decrement by 1; with is_rep=0, ECX SHALL be unchanged.
REQ-024 After mem_ack: is_rep=0, or decremented ECX=0, SHALL go to DONE; else back to ITER.
REQ-025 mem_ack outside WAIT SHALL be ignored.
REQ-026 DONE SHALL assert done for one cycle and return to IDLE; register values SHALL hold.
REQ-027 alu2_op SHALL be 4'b0101 in ITER and WAIT, 4'b0000 otherwise.
REQ-028 stall SHALL be 1 in ITER and WAIT, and 0 in IDLE and DONE.
REQ-029 flush=1 in any state SHALL force IDLE next edge, no done pulse, registers hold; flush has priority over mem_ack and load.
REQ-030 Minimum latency for single non-REP element: load edge -> ITER, +1 WAIT, mem_ack -> DONE; done visible 1 cycle after ack edge.
REQ-031 Ack in the cycle WAIT is entered SHALL be accepted (zero-wait memory gives 2 cycles per element).

Reset
REQ-032 rst=1 SHALL immediately force IDLE, iter_valid=0, done=0, stall=0, alu2_op=0000, esi_out=edi_out=ecx_out=0.
REQ-033 Reset deasserted mid-sequence SHALL resume from IDLE with no pending transfer.

Verification
REQ-034 REP MOVS, ECX=3, ESI=0x100, EDI=0x200, DF=0, ack each WAIT -> 3 iter_valid pulses, final ESI=0x10C, EDI=0x20C, ECX=0, single done.
REQ-035 REP STOS, ECX=0 -> no iter_valid, done one cycle after load, EDI unchanged.
REQ-036 Non-REP LODS, DF=1, ESI=0x0 -> one iter_valid, ESI=0xFFFFFFFC, ECX unchanged, EDI unchanged.
REQ-037 REP MOVS ECX=5, flush during 2nd WAIT -> IDLE next cycle, no done, ECX=4, stall=0.
REQ-038 Async rst asserted in WAIT between clock edges -> outputs zero immediately, IDLE after release.
REQ-039 mem_ack held high continuously, REP STOS ECX=2 -> ITER/WAIT alternate, 2 iterations, EDI +8, done once.

Source files
------------

// File: rtl/rep_str_seq.sv
// rep_str_seq -- sequencer for x86 string instructions (MOVS/STOS/LODS) with
// optional REP prefix. It latches ESI/EDI/ECX and DF at instruction entry,
// issues one element transfer at a time, steps the pointers and the count,
// and pulses done when the sequence completes.
//
// Ports:
//   clk, rst        clock (rising edge) and asynchronous active-high reset
//   valid_in        decoded instruction present at execute entry
//   str_op[1:0]     00 none, 01 MOVS, 10 STOS, 11 LODS
//   is_rep          REP prefix present
//   ecx_in/esi_in/edi_in[31:0]  architectural registers at instruction entry
//   DF_in           direction flag (0 increment, 1 decrement)
//   flush           abort any sequence, return to IDLE without done
//   mem_ack         memory finished the current element transfer
//   iter_valid      one-cycle request for one element transfer
//   esi_out/edi_out/ecx_out[31:0]  current pointer/count registers
//   alu2_op[3:0]    op code for the downstream ALU2 stage
//   stall           hold the upstream pipeline
//   done            one-cycle completion pulse
//   o_dbg_state[1:0] current FSM state (0 IDLE, 1 ITER, 2 WAIT, 3 DONE)
//
// Handshake: iter_valid is a one-cycle request raised in ITER; the sequencer
// then waits in WAIT for mem_ack, which may arrive in the very first WAIT
// cycle. mem_ack in any other state is ignored.
module rep_str_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [1:0]  str_op,
  input  logic        is_rep,
  input  logic [31:0] ecx_in,
  input  logic [31:0] esi_in,
  input  logic [31:0] edi_in,
  input  logic        DF_in,
  input  logic        flush,
  input  logic        mem_ack,
  output logic        iter_valid,
  output logic [31:0] esi_out,
  output logic [31:0] edi_out,
  output logic [31:0] ecx_out,
  output logic [3:0]  alu2_op,
  output logic        stall,
  output logic        done,
  output logic [1:0]  o_dbg_state
);

  localparam logic [1:0] OP_MOVS = 2'b01;
  localparam logic [1:0] OP_STOS = 2'b10;
  localparam logic [1:0] OP_LODS = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_esi;
  logic [31:0] r_edi;
  logic [31:0] r_ecx;
  logic        r_df;
  logic        r_rep;
  logic [1:0]  r_op;

  logic        w_load;
  logic        w_ack;
  logic [31:0] w_step;
  logic [31:0] w_esi_next;
  logic [31:0] w_edi_next;
  logic [31:0] w_ecx_next;

  // Flush blocks both a new load and an element completion.
  assign w_load = (r_state == S_IDLE) && valid_in && (str_op != 2'b00) && !flush;
  assign w_ack  = (r_state == S_WAIT) && mem_ack && !flush;

  // -4 is the two's-complement constant; 32-bit adds wrap naturally.
  assign w_step     = r_df ? 32'hFFFF_FFFC : 32'd4;
  assign w_esi_next = ((r_op == OP_MOVS) || (r_op == OP_LODS)) ? r_esi + w_step : r_esi;
  assign w_edi_next = ((r_op == OP_MOVS) || (r_op == OP_STOS)) ? r_edi + w_step : r_edi;
  assign w_ecx_next = r_rep ? r_ecx - 32'd1 : r_ecx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (flush) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_load) begin
            // REP with a zero count completes without touching memory.
            w_next = (is_rep && (ecx_in == 32'd0)) ? S_DONE : S_ITER;
          end
        end
        S_ITER: w_next = S_WAIT;
        S_WAIT: begin
          if (w_ack) begin
            w_next = (!r_rep || (w_ecx_next == 32'd0)) ? S_DONE : S_ITER;
          end
        end
        S_DONE: w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_esi <= 32'd0;
      r_edi <= 32'd0;
      r_ecx <= 32'd0;
      r_df  <= 1'b0;
      r_rep <= 1'b0;
      r_op  <= 2'b00;
    end else if (w_load) begin
      r_esi <= esi_in;
      r_edi <= edi_in;
      r_ecx <= ecx_in;
      r_df  <= DF_in;
      r_rep <= is_rep;
      r_op  <= str_op;
    end else if (w_ack) begin
      r_esi <= w_esi_next;
      r_edi <= w_edi_next;
      r_ecx <= w_ecx_next;
    end
  end

  assign iter_valid  = (r_state == S_ITER);
  assign stall       = (r_state == S_ITER) || (r_state == S_WAIT);
  assign alu2_op     = stall ? 4'b0101 : 4'b0000;
  // A flush arriving in DONE suppresses the completion pulse.
  assign done        = (r_state == S_DONE) && !flush;
  assign esi_out     = r_esi;
  assign edi_out     = r_edi;
  assign ecx_out     = r_ecx;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_rep_str_seq.sv
module tb_rep_str_seq;

  logic        clk;
  logic        rst;
  logic        valid_in;
  logic [1:0]  str_op;
  logic        is_rep;
  logic [31:0] ecx_in;
  logic [31:0] esi_in;
  logic [31:0] edi_in;
  logic        DF_in;
  logic        flush;
  logic        mem_ack;
  logic        iter_valid;
  logic [31:0] esi_out;
  logic [31:0] edi_out;
  logic [31:0] ecx_out;
  logic [3:0]  alu2_op;
  logic        stall;
  logic        done;
  logic [1:0]  o_dbg_state;

  int checks;
  int failures;

  rep_str_seq dut (
    .clk         (clk),
    .rst         (rst),
    .valid_in    (valid_in),
    .str_op      (str_op),
    .is_rep      (is_rep),
    .ecx_in      (ecx_in),
    .esi_in      (esi_in),
    .edi_in      (edi_in),
    .DF_in       (DF_in),
    .flush       (flush),
    .mem_ack     (mem_ack),
    .iter_valid  (iter_valid),
    .esi_out     (esi_out),
    .edi_out     (edi_out),
    .ecx_out     (ecx_out),
    .alu2_op     (alu2_op),
    .stall       (stall),
    .done        (done),
    .o_dbg_state (o_dbg_state)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks: inputs change only on the falling edge
  task automatic drive_load(input logic [1:0] op, input logic rep, input logic [31:0] ecx,
                            input logic [31:0] esi, input logic [31:0] edi, input logic df);
    @(negedge clk);
    valid_in = 1'b1;
    str_op   = op;
    is_rep   = rep;
    ecx_in   = ecx;
    esi_in   = esi;
    edi_in   = edi;
    DF_in    = df;
  endtask

  // Runs a sequence after drive_load until done is seen or the budget expires.
  // Acks every WAIT cycle (or holds mem_ack high when ack_always is set).
  task automatic run_seq(input int max_cycles, input bit ack_always,
                         output int n_iter, output int n_done, output int cycles,
                         output int bad_alu);
    n_iter  = 0;
    n_done  = 0;
    cycles  = 0;
    bad_alu = 0;
    while (cycles < max_cycles && n_done == 0) begin
      @(negedge clk);
      valid_in = 1'b0;
      cycles++;
      if (iter_valid) n_iter++;
      if (done) n_done++;
      if (alu2_op !== (stall ? 4'b0101 : 4'b0000)) bad_alu++;
      mem_ack = ack_always ? 1'b1 : (stall && !iter_valid);
    end
    @(negedge clk);
    mem_ack = 1'b0;
    if (done) n_done++;
    if (iter_valid) n_iter++;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #1;
    checks++;
    if ({iter_valid, done, stall, alu2_op} !== 7'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=0", {iter_valid, done, stall, alu2_op});
    end
    checks++;
    if ({esi_out, edi_out, ecx_out} !== 96'd0) begin
      failures++;
      $display("FAIL reset_regs esi=%h edi=%h ecx=%h exp=0", esi_out, edi_out, ecx_out);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_rep_movs;
    int ni, nd, cy, ba;
    drive_load(2'b01, 1'b1, 32'd3, 32'h100, 32'h200, 1'b0);
    run_seq(40, 1'b0, ni, nd, cy, ba);
    checks++;
    if (ni !== 3) begin failures++; $display("FAIL movs_iters got=%0d exp=3", ni); end
    checks++;
    if (nd !== 1) begin failures++; $display("FAIL movs_done got=%0d exp=1", nd); end
    checks++;
    if (esi_out !== 32'h10C || edi_out !== 32'h20C || ecx_out !== 32'd0) begin
      failures++;
      $display("FAIL movs_regs esi=%h edi=%h ecx=%h exp=10c/20c/0", esi_out, edi_out, ecx_out);
    end
    checks++;
    if (ba !== 0) begin failures++; $display("FAIL movs_alu2op bad_cycles=%0d exp=0", ba); end
    // 3 elements x 2 cycles, done appears in the cycle after the last ack
    checks++;
    if (cy !== 7) begin failures++; $display("FAIL movs_latency got=%0d exp=7", cy); end
  endtask

  task automatic test_rep_stos_zero;
    int ni, nd, cy, ba;
    drive_load(2'b10, 1'b1, 32'd0, 32'h40, 32'h80, 1'b0);
    run_seq(10, 1'b0, ni, nd, cy, ba);
    checks++;
    if (ni !== 0) begin failures++; $display("FAIL stos0_iters got=%0d exp=0", ni); end
    checks++;
    if (nd !== 1 || cy !== 1) begin
      failures++;
      $display("FAIL stos0_done done=%0d cycles=%0d exp=1/1", nd, cy);
    end
    checks++;
    if (edi_out !== 32'h80 || ecx_out !== 32'd0) begin
      failures++;
      $display("FAIL stos0_regs edi=%h ecx=%h exp=80/0", edi_out, ecx_out);
    end
  endtask

  task automatic test_lods_df1;
    int ni, nd, cy, ba;
    drive_load(2'b11, 1'b0, 32'd7, 32'h0, 32'h55, 1'b1);
    run_seq(10, 1'b0, ni, nd, cy, ba);
    checks++;
    if (ni !== 1 || nd !== 1 || cy !== 3) begin
      failures++;
      $display("FAIL lods_seq iters=%0d done=%0d cycles=%0d exp=1/1/3", ni, nd, cy);
    end
    checks++;
    if (esi_out !== 32'hFFFF_FFFC || ecx_out !== 32'd7 || edi_out !== 32'h55) begin
      failures++;
      $display("FAIL lods_regs esi=%h ecx=%h edi=%h exp=fffffffc/7/55", esi_out, ecx_out, edi_out);
    end
  endtask

  task automatic test_movs_wrap_up;
    int ni, nd, cy, ba;
    drive_load(2'b01, 1'b0, 32'd9, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0);
    run_seq(10, 1'b0, ni, nd, cy, ba);
    checks++;
    if (esi_out !== 32'd0 || edi_out !== 32'd0 || ecx_out !== 32'd9 || ni !== 1) begin
      failures++;
      $display("FAIL wrap_up esi=%h edi=%h ecx=%h iters=%0d exp=0/0/9/1",
               esi_out, edi_out, ecx_out, ni);
    end
  endtask

  task automatic test_idle_ignore;
    // str_op none plus a stray ack: nothing starts, registers hold
    @(negedge clk);
    valid_in = 1'b1;
    str_op   = 2'b00;
    esi_in   = 32'hDEAD_0000;
    mem_ack  = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (stall !== 1'b0 || iter_valid !== 1'b0 || done !== 1'b0 || esi_out !== 32'd0) begin
      failures++;
      $display("FAIL idle_ignore stall=%b iv=%b done=%b esi=%h exp=0/0/0/0",
               stall, iter_valid, done, esi_out);
    end
    valid_in = 1'b0;
    mem_ack  = 1'b0;
  endtask

  task automatic test_flush;
    int waits;
    int cy;
    bit seen_done;
    waits = 0;
    cy = 0;
    seen_done = 1'b0;
    drive_load(2'b01, 1'b1, 32'd5, 32'h100, 32'h200, 1'b0);
    while (waits < 2 && cy < 20) begin
      @(negedge clk);
      valid_in = 1'b0;
      cy++;
      if (stall && !iter_valid) begin
        waits++;
        mem_ack = 1'b1;
        if (waits == 2) flush = 1'b1;
      end else begin
        mem_ack = 1'b0;
      end
    end
    @(negedge clk);
    flush = 1'b0;
    mem_ack = 1'b0;
    if (done) seen_done = 1'b1;
    checks++;
    if (stall !== 1'b0 || iter_valid !== 1'b0 || ecx_out !== 32'd4 || esi_out !== 32'h104) begin
      failures++;
      $display("FAIL flush_state stall=%b iv=%b ecx=%h esi=%h exp=0/0/4/104",
               stall, iter_valid, ecx_out, esi_out);
    end
    repeat (3) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    checks++;
    if (seen_done !== 1'b0 || stall !== 1'b0) begin
      failures++;
      $display("FAIL flush_nodone done_seen=%b stall=%b exp=0/0", seen_done, stall);
    end
  endtask

  task automatic test_async_rst;
    drive_load(2'b01, 1'b1, 32'd3, 32'h300, 32'h400, 1'b0);
    @(negedge clk);
    valid_in = 1'b0;      // ITER
    @(negedge clk);       // WAIT
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({iter_valid, done, stall, alu2_op} !== 7'b0 ||
        {esi_out, edi_out, ecx_out} !== 96'd0) begin
      failures++;
      $display("FAIL async_rst ctrl=%b esi=%h edi=%h ecx=%h exp=0",
               {iter_valid, done, stall, alu2_op}, esi_out, edi_out, ecx_out);
    end
    @(negedge clk);
    rst = 1'b0;
    mem_ack = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (stall !== 1'b0 || iter_valid !== 1'b0 || done !== 1'b0 || o_dbg_state !== 2'd0) begin
      failures++;
      $display("FAIL rst_resume stall=%b iv=%b done=%b st=%0d exp=0/0/0/0",
               stall, iter_valid, done, o_dbg_state);
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_ack_held;
    int ni, nd, cy, ba;
    drive_load(2'b10, 1'b1, 32'd2, 32'h10, 32'h1000, 1'b0);
    run_seq(20, 1'b1, ni, nd, cy, ba);
    checks++;
    if (ni !== 2 || nd !== 1 || cy !== 5) begin
      failures++;
      $display("FAIL ackheld_seq iters=%0d done=%0d cycles=%0d exp=2/1/5", ni, nd, cy);
    end
    checks++;
    if (edi_out !== 32'h1008 || esi_out !== 32'h10 || ecx_out !== 32'd0) begin
      failures++;
      $display("FAIL ackheld_regs edi=%h esi=%h ecx=%h exp=1008/10/0", edi_out, esi_out, ecx_out);
    end
  endtask

  task automatic test_back_to_back;
    int ni, nd, cy, ba;
    // DF=1 REP MOVS of 2 straight after the previous sequence
    drive_load(2'b01, 1'b1, 32'd2, 32'h4, 32'h2000, 1'b1);
    run_seq(20, 1'b0, ni, nd, cy, ba);
    checks++;
    if (esi_out !== 32'hFFFF_FFFC || edi_out !== 32'h1FF8 || ecx_out !== 32'd0 || ni !== 2) begin
      failures++;
      $display("FAIL b2b_dec esi=%h edi=%h ecx=%h iters=%0d exp=fffffffc/1ff8/0/2",
               esi_out, edi_out, ecx_out, ni);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    valid_in = 1'b0;
    str_op   = 2'b00;
    is_rep   = 1'b0;
    ecx_in   = 32'd0;
    esi_in   = 32'd0;
    edi_in   = 32'd0;
    DF_in    = 1'b0;
    flush    = 1'b0;
    mem_ack  = 1'b0;
    rst      = 1'b0;
    test_reset();
    test_idle_ignore();
    test_rep_movs();
    test_rep_stos_zero();
    test_lods_df1();
    test_movs_wrap_up();
    test_flush();
    test_async_rst();
    test_ack_held();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
